// File: rtl/oisc_port_fifo_if.sv
// Bus-side and peripheral-side signal bundle for the buffered OISC port.
// Latency: none, wires only.
// Backpressure: carries tx_valid/tx_ready and rx_valid/rx_ready handshakes.
interface oisc_port_fifo_if #(
   parameter int DWIDTH = 8
);
   logic [3:0]        instr_dst;
   logic [7:0]        instr_src;
   logic [DWIDTH-1:0] bus_wdata;
   logic [DWIDTH-1:0] bus_rdata;
   logic              bus_oe;
   logic [DWIDTH-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DWIDTH-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;

   // Port block view
   modport slave (
      input  instr_dst, instr_src, bus_wdata, tx_ready, rx_data, rx_valid,
      output bus_rdata, bus_oe, tx_data, tx_valid, rx_ready
   );

   // Bus master / peripheral view
   modport master (
      output instr_dst, instr_src, bus_wdata, tx_ready, rx_data, rx_valid,
      input  bus_rdata, bus_oe, tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/oisc_port_fifo.sv
// FIFO-backed OISC bus port: bus moves push TX / pop RX, plus a status register.
// Latency: bus push visible on tx_* after one edge; RX push readable next cycle (FWFT).
// Backpressure: tx_valid/tx_ready drain; rx_ready = RX not full; full TX push drops + sets tx_ovf.
module oisc_port_fifo #(
   parameter int         DWIDTH    = 8,
   parameter int         DEPTH     = 4,
   parameter logic [3:0] ADDR_TX   = 4'd12,
   parameter logic [7:0] ADDR_RX   = 8'd35,
   parameter logic [7:0] ADDR_STAT = 8'd34
) (
   input logic             clk,
   input logic             rst_n,
   oisc_port_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DWIDTH-1:0] tx_mem_q [DEPTH];
   logic [DWIDTH-1:0] rx_mem_q [DEPTH];

   logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push_req, rx_pop_req, stat_rd;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic [7:0] status;

   // Flags come only from registered pointers; the extra MSB separates full from empty
   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign tx_full  = (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]) && (tx_wptr_q[AW] != tx_rptr_q[AW]);
   assign rx_empty = (rx_wptr_q == rx_rptr_q);
   assign rx_full  = (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]) && (rx_wptr_q[AW] != rx_rptr_q[AW]);

   assign tx_push_req = (bus.instr_dst == ADDR_TX);
   assign rx_pop_req  = (bus.instr_src == ADDR_RX);
   assign stat_rd     = (bus.instr_src == ADDR_STAT);

   // A full TX still accepts a push when the head leaves in the same cycle
   assign tx_pop  = !tx_empty && bus.tx_ready;
   assign tx_push = tx_push_req && (!tx_full || tx_pop);
   assign rx_push = bus.rx_valid && !rx_full;
   assign rx_pop  = rx_pop_req && !rx_empty;

   assign status = {2'b00, rx_udf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

   // Next-state pointers and sticky errors; a new error beats the read-to-clear
   always_comb begin
      tx_wptr_d = tx_wptr_q;
      tx_rptr_d = tx_rptr_q;
      rx_wptr_d = rx_wptr_q;
      rx_rptr_d = rx_rptr_q;
      tx_ovf_d  = tx_ovf_q && !stat_rd;
      rx_udf_d  = rx_udf_q && !stat_rd;
      if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
      if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
      if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
      if (rx_pop_req && rx_empty)            rx_udf_d = 1'b1;
   end

   // Pointer and error-flag registers; reset empties both queues
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         tx_ovf_q  <= 1'b0;
         rx_udf_q  <= 1'b0;
      end else begin
         tx_wptr_q <= tx_wptr_d;
         tx_rptr_q <= tx_rptr_d;
         rx_wptr_q <= rx_wptr_d;
         rx_rptr_q <= rx_rptr_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_udf_q  <= rx_udf_d;
      end
   end

   // Queue storage; contents are only visible through the pointers so need no reset
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.bus_wdata;
      if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= bus.rx_data;
   end

   // Bus read mux: RX head fall-through, status, or zero when not selected
   always_comb begin
      bus.bus_rdata = '0;
      if (rx_pop_req) begin
         if (!rx_empty) bus.bus_rdata = rx_mem_q[rx_rptr_q[AW-1:0]];
      end else if (stat_rd) begin
         bus.bus_rdata = DWIDTH'(status);
      end
   end

   assign bus.bus_oe   = rx_pop_req || stat_rd;
   assign bus.tx_data  = tx_mem_q[tx_rptr_q[AW-1:0]];
   assign bus.tx_valid = !tx_empty;
   assign bus.rx_ready = !rx_full;
endmodule

// File: tb/tb_oisc_port_fifo.sv
// Bench for oisc_port_fifo: directed vector table, reset corner case, queue-based random model.
module tb_oisc_port_fifo;
   localparam int         DEPTH = 4;
   localparam logic [3:0] T  = 4'd12;
   localparam logic [3:0] D0 = 4'd0;
   localparam logic [7:0] R  = 8'd35;
   localparam logic [7:0] S  = 8'd34;
   localparam logic [7:0] I  = 8'd0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   oisc_port_fifo_if #(.DWIDTH(8)) bus_if ();

   oisc_port_fifo #(
      .DWIDTH(8), .DEPTH(DEPTH), .ADDR_TX(T), .ADDR_RX(R), .ADDR_STAT(S)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus_if.slave)
   );

   typedef struct {
      logic [3:0] dst;
      logic [7:0] src;
      logic [7:0] wd;
      logic       trdy;
      logic [7:0] rxd;
      logic       rxv;
      logic [7:0] erd;
      logic       eoe;
      logic       etxv;
      logic [7:0] etxd;
      logic       erxr;
   } vec_t;

   vec_t tbl[$];

   // reference model state
   logic [7:0] tq[$];
   logic [7:0] rq[$];
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] dst, input logic [7:0] src, input logic [7:0] wd,
                         input logic trdy, input logic [7:0] rxd, input logic rxv);
      bus_if.instr_dst = dst;
      bus_if.instr_src = src;
      bus_if.bus_wdata = wd;
      bus_if.tx_ready  = trdy;
      bus_if.rx_data   = rxd;
      bus_if.rx_valid  = rxv;
   endtask

   // inputs change on the falling edge; outputs are sampled 1 time unit later
   task automatic drive(input logic [3:0] dst, input logic [7:0] src, input logic [7:0] wd,
                        input logic trdy, input logic [7:0] rxd, input logic rxv);
      @(negedge clk);
      set_in(dst, src, wd, trdy, rxd, rxv);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] erd, input logic eoe,
                            input logic etxv, input logic [7:0] etxd, input logic erxr);
      chk({tag, ".rdata"}, bus_if.bus_rdata, erd);
      chk({tag, ".oe"}, bus_if.bus_oe, eoe);
      chk({tag, ".txv"}, bus_if.tx_valid, etxv);
      chk({tag, ".rxr"}, bus_if.rx_ready, erxr);
      if (etxv) chk({tag, ".txd"}, bus_if.tx_data, etxd);
   endtask

   task automatic add(input logic [3:0] dst, input logic [7:0] src, input logic [7:0] wd,
                      input logic trdy, input logic [7:0] rxd, input logic rxv,
                      input logic [7:0] erd, input logic eoe, input logic etxv,
                      input logic [7:0] etxd, input logic erxr);
      vec_t v;
      v = '{dst, src, wd, trdy, rxd, rxv, erd, eoe, etxv, etxd, erxr};
      tbl.push_back(v);
   endtask

   // One cycle against the queue model: expected outputs from model state, then apply the rules
   task automatic mstep(input string tag, input logic [3:0] dst, input logic [7:0] src,
                        input logic [7:0] wd, input logic trdy, input logic [7:0] rxd,
                        input logic rxv);
      logic [7:0] stat, erd, etxd;
      logic       etxv, popped, pre_full;
      int         rn;
      drive(dst, src, wd, trdy, rxd, rxv);
      etxv = (tq.size() != 0);
      etxd = etxv ? tq[0] : 8'h00;
      stat = {2'b00, m_udf, m_ovf, rq.size() == DEPTH, rq.size() == 0,
              tq.size() == DEPTH, tq.size() == 0};
      if (src == R)      erd = (rq.size() != 0) ? rq[0] : 8'h00;
      else if (src == S) erd = stat;
      else               erd = 8'h00;
      check_out(tag, erd, (src == R) || (src == S), etxv, etxd, rq.size() < DEPTH);
      popped   = etxv && trdy;
      pre_full = (tq.size() == DEPTH);
      if (popped) void'(tq.pop_front());
      if (dst == T && (!pre_full || popped)) tq.push_back(wd);
      rn = rq.size();
      if (src == R && rn > 0) void'(rq.pop_front());
      if (rxv && rn < DEPTH) rq.push_back(rxd);
      if (src == S) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (dst == T && pre_full && !popped) m_ovf = 1'b1;
      if (src == R && rn == 0)             m_udf = 1'b1;
   endtask

   initial begin
      set_in(D0, S, 8'h00, 1'b0, 8'h00, 1'b0);
      #1;
      check_out("in_reset", 8'h05, 1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // dst, src, wd, trdy, rxd, rxv | rdata, oe, txv, txd, rxr
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 8'h00, 1);
      add(D0, R, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h25, 1, 0, 8'h00, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 8'h00, 1);
      add(T,  I, 8'hA1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1);
      add(T,  I, 8'hA2, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA1, 1);
      add(T,  I, 8'hA3, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA1, 1);
      add(T,  I, 8'hA4, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA1, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h06, 1, 1, 8'hA1, 1);
      add(T,  I, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA1, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h16, 1, 1, 8'hA1, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h06, 1, 1, 8'hA1, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hA1, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hA2, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hA3, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hA4, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 8'h00, 1);
      add(T,  I, 8'hC1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1);
      add(T,  I, 8'hC2, 0, 8'h00, 0, 8'h00, 0, 1, 8'hC1, 1);
      add(T,  I, 8'hC3, 0, 8'h00, 0, 8'h00, 0, 1, 8'hC1, 1);
      add(T,  I, 8'hC4, 0, 8'h00, 0, 8'h00, 0, 1, 8'hC1, 1);
      add(T,  I, 8'hB0, 1, 8'h00, 0, 8'h00, 0, 1, 8'hC1, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h06, 1, 1, 8'hC2, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hC2, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hC3, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hC4, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'hB0, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 8'h00, 1);
      add(D0, I, 8'h00, 0, 8'h11, 1, 8'h00, 0, 0, 8'h00, 1);
      add(D0, I, 8'h00, 0, 8'h12, 1, 8'h00, 0, 0, 8'h00, 1);
      add(D0, I, 8'h00, 0, 8'h13, 1, 8'h00, 0, 0, 8'h00, 1);
      add(D0, I, 8'h00, 0, 8'h14, 1, 8'h00, 0, 0, 8'h00, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h09, 1, 0, 8'h00, 0);
      add(D0, R, 8'h00, 0, 8'h99, 1, 8'h11, 1, 0, 8'h00, 0);
      add(D0, R, 8'h00, 0, 8'h00, 0, 8'h12, 1, 0, 8'h00, 1);
      add(D0, R, 8'h00, 0, 8'h00, 0, 8'h13, 1, 0, 8'h00, 1);
      add(D0, R, 8'h00, 0, 8'h00, 0, 8'h14, 1, 0, 8'h00, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 8'h00, 1);
      add(D0, R, 8'h00, 0, 8'h55, 1, 8'h00, 1, 0, 8'h00, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h21, 1, 0, 8'h00, 1);
      add(T,  R, 8'h77, 0, 8'h00, 0, 8'h55, 1, 0, 8'h00, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h04, 1, 1, 8'h77, 1);
      add(D0, I, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1, 8'h77, 1);
      add(D0, S, 8'h00, 0, 8'h00, 0, 8'h05, 1, 0, 8'h00, 1);

      foreach (tbl[k]) begin
         drive(tbl[k].dst, tbl[k].src, tbl[k].wd, tbl[k].trdy, tbl[k].rxd, tbl[k].rxv);
         check_out($sformatf("vec%0d", k), tbl[k].erd, tbl[k].eoe, tbl[k].etxv,
                   tbl[k].etxd, tbl[k].erxr);
      end

      // reset asserted mid-cycle with three TX words and one RX word queued
      for (int i = 0; i < 3; i++) drive(T, I, 8'hE0 + 8'(i), 1'b0, 8'h66, (i == 0));
      @(negedge clk);
      set_in(D0, I, 8'h00, 1'b0, 8'h00, 1'b0);
      #1;
      chk("pre_rst.txv", bus_if.tx_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst.txv", bus_if.tx_valid, 1'b0);
      chk("rst.rxr", bus_if.rx_ready, 1'b1);
      set_in(T, S, 8'hEE, 1'b1, 8'h77, 1'b1);
      #1;
      chk("rst.stat", bus_if.bus_rdata, 8'h05);
      chk("rst.oe", bus_if.bus_oe, 1'b1);
      @(negedge clk);
      set_in(D0, I, 8'h00, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_hold.txv", bus_if.tx_valid, 1'b0);
      mstep("post_rst", D0, S, 8'h00, 1'b0, 8'h00, 1'b0);

      // streaming 3*DEPTH words through both queues across pointer wrap
      for (int i = 0; i < 3 * DEPTH + 1; i++)
         mstep($sformatf("stream%0d", i), T, (i == 0) ? I : R, 8'h40 + 8'(i), (i != 0),
               8'h80 + 8'(i), (i < 3 * DEPTH));
      mstep("stream_drain", D0, I, 8'h00, 1'b1, 8'h00, 1'b0);
      mstep("stream_stat", D0, S, 8'h00, 1'b0, 8'h00, 1'b0);

      // random traffic; first half leans towards filling, second towards draining
      for (int i = 0; i < 600; i++) begin
         logic [3:0] dst;
         logic [7:0] src;
         int         r;
         bit         fill;
         fill = (i < 300);
         dst  = ($urandom_range(0, 2) != 0) ? T : 4'($urandom_range(0, 11));
         r    = $urandom_range(0, 5);
         src  = (r == 0) ? R : (r == 1) ? S : 8'($urandom_range(0, 33));
         if (fill && r == 0 && $urandom_range(0, 1) == 0) src = I;
         mstep($sformatf("rnd%0d", i), dst, src, 8'($urandom),
               fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
               8'($urandom), fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
